// File: rtl/uart_pkg.sv
// Shared definitions for the host-side UART transmit path.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int DEF_FIFO_DEPTH   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Occupancy is tracked in a separate level register so full and empty stay
// distinguishable when the wrapping pointers are equal. A push against a full
// FIFO is dropped even if a pop happens on the same edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_BITS-1:0]          din,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level_nxt;
  logic                 push_ok;
  logic                 pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Next occupancy: a simultaneous accepted push and pop leaves it unchanged.
  always_comb begin
    level_nxt = level;
    case ({push_ok, pop_ok})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Storage array; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(FIFO_DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: FIFO-buffered bytes serialised as 8N1 frames.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1, 11-bit frames).
// Bit timing is derived directly from clk via CLKS_PER_BIT (>= 2).
module uart_host_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  wrData,
  input  logic                        wrEn,
  output logic                        tx,
  output logic                        full,
  output logic                        empty,
  output logic                        busy,
  output logic                        txDone,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            bit_idx;
  logic [DATA_BITS-1:0]  shift;
  logic [DATA_BITS-1:0]  fifo_dout;
  logic                  last;
  logic                  pop;
`ifdef UART_TX_PARITY_EN
  logic                  par;
`endif

  // Bit boundary is the final count of each bit period.
  assign last = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  // Dequeue only from IDLE or on the final STOP cycle, so frames run gap-free.
  assign pop  = !empty && ((state == IDLE) || ((state == STOP) && last));
  assign busy = (state != IDLE);

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wrEn),
    .pop   (pop),
    .din   (wrData),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Frame sequencer with baud counter, shift register and registered line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      txDone  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      txDone <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift   <= fifo_dout;
`ifdef UART_TX_PARITY_EN
            par     <= ^fifo_dout;
`endif
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (last) begin
            cnt   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (last) begin
            cnt <= '0;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (last) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          // Registered so the pulse coincides with the final stop cycle.
          if (cnt == CNT_W'(CLKS_PER_BIT - 2)) txDone <= 1'b1;
          if (last) begin
            cnt <= '0;
            if (!empty) begin
              shift   <= fifo_dout;
`ifdef UART_TX_PARITY_EN
              par     <= ^fifo_dout;
`endif
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_host_tx.md
# uart_host_tx

Host-side UART transmit engine: accepts bytes from a parallel write port into an internal FIFO and serialises them as 8N1 frames (optionally 8E1) on `tx`. It is the opposite end of the UART receive path: it produces the serial stream a `Receiver` consumes and drives external UART links from on-chip logic. It generates its own bit timing from `clk`, so it needs no separate baud-rate generator.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per serial bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 8: byte entries in the write FIFO. Must be a power of two, ≥ 2.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `wrData` in 8: byte to enqueue.
- `wrEn` in 1: push `wrData` on this edge if `full`=0.
- `tx` out 1: serial line, idle high.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries.
- `busy` out 1: a frame is on the line (state ≠ IDLE).
- `txDone` out 1: one-cycle pulse at the end of each stop bit.
- `level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `tx`=1. If FIFO is not empty, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: drive shift[0], LSB first. After each CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7, go to PARITY (macro on) or STOP.
- PARITY: `tx` = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, assert `txDone`. If the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0. The bit boundary is at count = CLKS_PER_BIT-1.
- FIFO write when `full`=1 is dropped, even if a pop occurs on the same edge. No overflow flag.
- Pop occurs only from IDLE or the last STOP cycle, never when `empty`=1.
- Simultaneous push and pop with FIFO non-full and non-empty: `level` is unchanged and the data order is preserved.
- Pointers wrap modulo FIFO_DEPTH. `level` distinguishes full from empty.
- `wrData` is sampled only on the edge where the push is accepted.

## Timing
- Reset values: `tx`=1, `full`=0, `empty`=1, `busy`=0, `txDone`=0, `level`=0, FSM in IDLE, pointers 0.
- Reset asserted mid-frame forces `tx`=1 immediately (asynchronous) and discards the FIFO contents and the frame in progress.
- Write into an empty FIFO while IDLE:
  - push at edge N;
  - `empty` falls after edge N;
  - pop and START entry at edge N+1;
  - `tx` falls after edge N+1;
  - `level` returns to 0 after edge N+1.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- `txDone` is high during the final STOP cycle. `busy` drops on the following edge only if the FIFO is empty.
- `full`/`empty`/`level` are registered and update on the edge after the push/pop.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state is present and frames are 8E1, 11 bits.
- Undefined: no PARITY state and no parity logic; frames are 8N1, 10 bits.

## Structure
- Shared package `uart_pkg` holds:
  - `DATA_BITS`=8;
  - the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - the default constants for CLKS_PER_BIT and FIFO_DEPTH.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with push/pop, data out, full/empty/level, and asynchronous active-high reset.
- The FSM, baud counter, and shift register live in `uart_host_tx`.

## Test plan
The bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset check: assert `reset` mid-frame of 0xA5 → `tx`=1 within the same cycle, then `empty`=1, `level`=0, `busy`=0.
- Single byte: write 0x55 when idle → `tx` falls 2 edges after the push. Line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 4 cycles, 40 cycles total. One `txDone` pulse.
- Back-to-back: write 0x01, 0xFF, 0x80 consecutively → three frames with no idle gap between stop and start, three `txDone` pulses, then `busy`=0.
- Overflow: while the first frame is active, push 6 bytes 0x10..0x15 → `full`=1 after 4 queued. The extra writes are dropped. The line carries 0x10, 0x11, 0x12, 0x13, 0x14 (the first is popped immediately) and no 0x15.
- Simultaneous push and pop: push on the last STOP cycle with `level`=2 → `level` stays 2 and order is preserved.
- Parity (macro on): send 0x55 → parity bit 0, 44-cycle frame. Send 0x07 → parity bit 1.
